// File: rtl/dmrs_rd_sched_if.sv
// dmrs_rd_sched_if
// Bundles the snooped write strobe, replay request and read-side
// handshake of the DMRS sample buffer scheduler.
//   slave  : the scheduler (consumes DMRS_valid/num_passes/rd_start/rd_ready,
//            produces read_ptr/rd_valid/rd_last/pass_idx/wr_len/busy/done/overrun)
//   master : the environment driving and observing the scheduler
interface dmrs_rd_sched_if #(
    parameter int ADDR_W = 10,
    parameter int PASS_W = 4
);
    logic              DMRS_valid;
    logic [PASS_W-1:0] num_passes;
    logic              rd_start;
    logic              rd_ready;
    logic [ADDR_W-1:0] read_ptr;
    logic              rd_valid;
    logic              rd_last;
    logic [PASS_W-1:0] pass_idx;
    logic [ADDR_W-1:0] wr_len;
    logic              busy;
    logic              done;
    logic              overrun;

    modport slave (
        input  DMRS_valid, num_passes, rd_start, rd_ready,
        output read_ptr, rd_valid, rd_last, pass_idx, wr_len, busy, done, overrun
    );

    modport master (
        output DMRS_valid, num_passes, rd_start, rd_ready,
        input  read_ptr, rd_valid, rd_last, pass_idx, wr_len, busy, done, overrun
    );
endinterface

// File: rtl/dmrs_rd_sched.sv
// dmrs_rd_sched
// Read-side scheduler for the DMRS sample buffer. Counts the samples of the
// current write burst by snooping the buffer write strobe, then replays the
// stored sequence num_passes times toward resource-element mapping with a
// valid/ready/last handshake. A write burst arriving mid-replay aborts the
// replay and raises the sticky overrun flag.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : dmrs_rd_sched_if.slave (strobe snoop, replay request,
//                read pointer/handshake and status outputs)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing stored since reset
// CAPTURE | write burst in progress, counting samples
// LOADED  | burst stored, waiting for a replay request
// READ    | replaying stored samples, one pass per data symbol
// DONE    | one-cycle completion pulse, data retained for later replay
module dmrs_rd_sched #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 600,
    parameter int PASS_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    dmrs_rd_sched_if.slave     bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_LOADED  = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [PASS_W-1:0] ONE_P   = PASS_W'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] wr_len;
    logic [ADDR_W-1:0] read_ptr;
    logic [PASS_W-1:0] pass_idx;
    logic [PASS_W-1:0] passes_lat;
    logic              overrun;
    logic              rd_valid;
    logic              rd_last;

    assign rd_valid = (state == S_READ);
    // wr_len is always >= 1 once READ is reachable, so wr_len-1 never underflows there
    assign rd_last  = rd_valid && (read_ptr == (wr_len - ONE_A));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_cnt     <= '0;
            wr_len     <= '0;
            read_ptr   <= '0;
            pass_idx   <= '0;
            passes_lat <= '0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.DMRS_valid) begin
                        state  <= S_CAPTURE;
                        wr_cnt <= ONE_A;
                    end
                end
                S_CAPTURE: begin
                    if (bus.DMRS_valid) begin
                        if (wr_cnt == DEPTH_V) begin
                            overrun <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + ONE_A;
                        end
                    end else begin
                        wr_len <= wr_cnt;
                        state  <= S_LOADED;
                    end
                end
                S_LOADED: begin
                    // a new burst takes precedence over a simultaneous replay request
                    if (bus.DMRS_valid) begin
                        state  <= S_CAPTURE;
                        wr_cnt <= ONE_A;
                    end else if (bus.rd_start && (bus.num_passes != '0)) begin
                        state      <= S_READ;
                        read_ptr   <= '0;
                        pass_idx   <= '0;
                        passes_lat <= bus.num_passes;
                    end
                end
                S_READ: begin
                    if (bus.DMRS_valid) begin
                        // buffer is being overwritten under us; abandon the replay
                        overrun  <= 1'b1;
                        state    <= S_CAPTURE;
                        wr_cnt   <= ONE_A;
                        read_ptr <= '0;
                    end else if (bus.rd_ready) begin
                        if (rd_last) begin
                            read_ptr <= '0;
                            if (pass_idx == (passes_lat - ONE_P)) begin
                                state <= S_DONE;
                            end else begin
                                pass_idx <= pass_idx + ONE_P;
                            end
                        end else begin
                            read_ptr <= read_ptr + ONE_A;
                        end
                    end
                end
                S_DONE: begin
                    // a strobe here is the first sample of a new burst, so count it
                    if (bus.DMRS_valid) begin
                        state  <= S_CAPTURE;
                        wr_cnt <= ONE_A;
                    end else begin
                        state <= S_LOADED;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.read_ptr = read_ptr;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_last  = rd_last;
    assign bus.pass_idx = pass_idx;
    assign bus.wr_len   = wr_len;
    assign bus.busy     = (state == S_CAPTURE) || (state == S_READ);
    assign bus.done     = (state == S_DONE);
    assign bus.overrun  = overrun;
endmodule

// File: tb/tb_dmrs_rd_sched.sv
// tb_dmrs_rd_sched
// Directed bench for dmrs_rd_sched. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_dmrs_rd_sched;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dmrs_rd_sched_if #(.ADDR_W(10), .PASS_W(4)) bus ();

    dmrs_rd_sched #(.ADDR_W(10), .DEPTH(600), .PASS_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // strobe held high for n rising edges, then low for one edge (-> LOADED)
    task automatic burst(input int n);
        bus.DMRS_valid = 1'b1;
        repeat (n) @(negedge clk);
        bus.DMRS_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic start(input int passes);
        bus.num_passes = 4'(passes);
        bus.rd_start   = 1'b1;
        @(negedge clk);
        bus.rd_start   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ptr"},  32'(bus.read_ptr), 0);
        chk({tag, "_val"},  32'(bus.rd_valid), 0);
        chk({tag, "_last"}, 32'(bus.rd_last),  0);
        chk({tag, "_pass"}, 32'(bus.pass_idx), 0);
        chk({tag, "_len"},  32'(bus.wr_len),   0);
        chk({tag, "_busy"}, 32'(bus.busy),     0);
        chk({tag, "_done"}, 32'(bus.done),     0);
        chk({tag, "_ovr"},  32'(bus.overrun),  0);
    endtask

    initial begin
        int n, hs, lasts, eptr, epass;
        bit seen;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.DMRS_valid = 1'b0;
        bus.num_passes = '0;
        bus.rd_start   = 1'b0;
        bus.rd_ready   = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b0;
        @(negedge clk);

        // basic replay, 12 samples, one pass
        bus.DMRS_valid = 1'b1;
        @(negedge clk);
        chk("cap_busy", 32'(bus.busy), 1);
        repeat (11) @(negedge clk);
        bus.DMRS_valid = 1'b0;
        @(negedge clk);
        chk("b_len", 32'(bus.wr_len), 12);
        chk("b_busy_loaded", 32'(bus.busy), 0);
        start(1);
        for (int i = 0; i < 12; i++) begin
            chk("b_val",  32'(bus.rd_valid), 1);
            chk("b_ptr",  32'(bus.read_ptr), 32'(i));
            chk("b_last", 32'(bus.rd_last),  (i == 11) ? 1 : 0);
            chk("b_done", 32'(bus.done),     0);
            @(negedge clk);
        end
        chk("b_done_pulse", 32'(bus.done), 1);
        chk("b_done_val",   32'(bus.rd_valid), 0);
        @(negedge clk);
        chk("b_done_clear", 32'(bus.done), 0);
        chk("b_idle_busy",  32'(bus.busy), 0);

        // multi-pass with backpressure: 5 samples, 3 passes, ready low every 3rd cycle
        burst(5);
        chk("m_len", 32'(bus.wr_len), 5);
        start(3);
        n = 0; hs = 0; lasts = 0; eptr = 0; epass = 0; seen = 0;
        while (!seen && n < 100) begin
            if (bus.done) begin
                seen = 1;
            end else begin
                chk("m_val",  32'(bus.rd_valid), 1);
                chk("m_ptr",  32'(bus.read_ptr), 32'(eptr));
                chk("m_pass", 32'(bus.pass_idx), 32'(epass));
                chk("m_last", 32'(bus.rd_last),  (eptr == 4) ? 1 : 0);
                bus.rd_ready = (n % 3 != 2);
                if (bus.rd_ready) begin
                    hs++;
                    if (eptr == 4) begin
                        lasts++;
                        eptr = 0;
                        epass++;
                    end else begin
                        eptr++;
                    end
                end
                n++;
                @(negedge clk);
            end
        end
        bus.rd_ready = 1'b1;
        chk("m_done_seen", 32'(seen), 1);
        chk("m_hs",        32'(hs), 15);
        chk("m_lasts",     32'(lasts), 3);
        chk("m_done_val",  32'(bus.rd_valid), 0);
        @(negedge clk);

        // collision: new burst at read_ptr 7 of a 20-sample replay
        burst(20);
        chk("c_len", 32'(bus.wr_len), 20);
        start(1);
        n = 0;
        while (bus.read_ptr != 10'd7 && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("c_reach7", 32'(bus.read_ptr), 7);
        chk("c_ovr0",   32'(bus.overrun), 0);
        bus.DMRS_valid = 1'b1;
        @(negedge clk);
        chk("c_ovr",  32'(bus.overrun),  1);
        chk("c_val",  32'(bus.rd_valid), 0);
        chk("c_busy", 32'(bus.busy),     1);
        chk("c_done", 32'(bus.done),     0);
        repeat (3) @(negedge clk);
        bus.DMRS_valid = 1'b0;
        @(negedge clk);
        chk("c_newlen", 32'(bus.wr_len),  4);
        chk("c_sticky", 32'(bus.overrun), 1);
        chk("c_val2",   32'(bus.rd_valid), 0);

        // start rules: rd_start during CAPTURE is dropped, not queued
        bus.DMRS_valid = 1'b1;
        @(negedge clk);
        bus.num_passes = 4'd1;
        bus.rd_start   = 1'b1;
        @(negedge clk);
        bus.rd_start   = 1'b0;
        chk("s_cap_val", 32'(bus.rd_valid), 0);
        @(negedge clk);
        bus.DMRS_valid = 1'b0;
        @(negedge clk);
        chk("s_cap_len", 32'(bus.wr_len), 3);
        @(negedge clk);
        chk("s_noqueue", 32'(bus.rd_valid), 0);
        // num_passes = 0 is ignored
        start(0);
        chk("s_zero_val",  32'(bus.rd_valid), 0);
        chk("s_zero_busy", 32'(bus.busy), 0);
        // strobe and start together: strobe wins
        bus.DMRS_valid = 1'b1;
        bus.num_passes = 4'd2;
        bus.rd_start   = 1'b1;
        @(negedge clk);
        bus.rd_start   = 1'b0;
        bus.DMRS_valid = 1'b0;
        chk("s_both_val",  32'(bus.rd_valid), 0);
        chk("s_both_busy", 32'(bus.busy), 1);
        @(negedge clk);
        chk("s_both_len", 32'(bus.wr_len), 1);

        // single-sample burst: every beat is last, two passes
        start(2);
        chk("one_val0",  32'(bus.rd_valid), 1);
        chk("one_last0", 32'(bus.rd_last),  1);
        chk("one_ptr0",  32'(bus.read_ptr), 0);
        chk("one_pass0", 32'(bus.pass_idx), 0);
        @(negedge clk);
        chk("one_last1", 32'(bus.rd_last),  1);
        chk("one_ptr1",  32'(bus.read_ptr), 0);
        chk("one_pass1", 32'(bus.pass_idx), 1);
        @(negedge clk);
        chk("one_done", 32'(bus.done), 1);
        @(negedge clk);

        // async reset between edges in the middle of a replay
        burst(8);
        start(2);
        repeat (3) @(negedge clk);
        chk("r_pre_ptr", 32'(bus.read_ptr), 3);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("r_nodone", 32'(bus.done), 0);
        chk("r_idle",   32'(bus.busy), 0);
        burst(6);
        chk("r_len", 32'(bus.wr_len),  6);
        chk("r_ovr", 32'(bus.overrun), 0);

        // overlength burst saturates at DEPTH
        burst(605);
        chk("o_len", 32'(bus.wr_len),  600);
        chk("o_ovr", 32'(bus.overrun), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
